uart_byte_rx: RTL and testbench

//  Serial-to-parallel UART receiver (8N1, LSB first). Sits directly upstream of the
//  row-sum FIFO controller: turns the board rx pin into a one-cycle pi_flag strobe

---
 rtl/uart_byte_rx_if.sv | 22 ++
 rtl/uart_byte_rx.sv | 131 +++++++++++++
 tb/tb_uart_byte_rx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_byte_rx_if.sv
// Received-byte port of the UART receiver: serial line in, strobed byte and framing error out.
// master = receiver side (drives the strobes), slave = downstream consumer (drives nothing but sees all).
interface uart_byte_rx_if;
    logic       rx;
    logic       po_flag;
    logic [7:0] po_data;
    logic       frame_err;

    modport master (
        input  rx,
        output po_flag,
        output po_data,
        output frame_err
    );

    modport slave (
        input rx,
        input po_flag,
        input po_data,
        input frame_err
    );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: po_flag/frame_err strobe 9*BAUD_MAX+BIT_MID+1 clocks after start-edge detection.
// No backpressure: one byte per 10 bit times, the consumer must take every strobe.
module uart_byte_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 9_600
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    uart_byte_rx_if.master bus
);

    localparam int BAUD_MAX = CLK_FREQ / UART_BPS;
    localparam int BIT_MID  = BAUD_MAX / 2;
    localparam int CNT_W    = (BAUD_MAX > 2) ? $clog2(BAUD_MAX) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_MAX - 1);
    localparam logic [CNT_W-1:0] BAUD_MID  = CNT_W'(BIT_MID);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rx_s1;
    logic             rx_s2;
    logic             rx_s3;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift;
    logic             flag_q;
    logic [7:0]       data_q;
    logic             err_q;
    logic             flag_nxt;
    logic             err_nxt;
    logic             start_edge;
    logic             at_mid;
    logic             at_wrap;

    // Synchroniser resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= bus.rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign start_edge = rx_s3 & ~rx_s2;
    assign at_mid     = (baud_cnt == BAUD_MID);
    assign at_wrap    = (baud_cnt == BAUD_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        flag_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (at_mid && rx_s2) begin
                    state_nxt = IDLE;
                end else if (at_wrap) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (at_wrap && (bit_cnt == 4'd8)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Leave half a bit early so a back-to-back start bit is not missed.
                if (at_mid) begin
                    state_nxt = IDLE;
                    flag_nxt  = rx_s2;
                    err_nxt   = ~rx_s2;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
            shift    <= 8'h00;
        end else if (state == IDLE) begin
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
        end else begin
            baud_cnt <= at_wrap ? '0 : baud_cnt + 1'b1;
            if ((state == DATA) && at_mid) begin
                shift[bit_cnt[2:0]] <= rx_s2;
                bit_cnt             <= bit_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            flag_q <= 1'b0;
            err_q  <= 1'b0;
            data_q <= 8'h00;
        end else begin
            flag_q <= flag_nxt;
            err_q  <= err_nxt;
            if (flag_nxt) begin
                data_q <= shift;
            end
        end
    end

    assign bus.po_flag   = flag_q;
    assign bus.po_data   = data_q;
    assign bus.frame_err = err_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: a frame-level model predicts each strobe's cycle and byte.
module tb_uart_byte_rx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int UART_BPS = 5_000_000;
    localparam int BAUD     = 10;
    // rx driven just after posedge n: sync 2 + detect, then 9*10+5+1 to the strobe.
    localparam int LAT      = 1 + 2 + 9 * BAUD + 5 + 1;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    always #5 sys_clk = ~sys_clk;

    uart_byte_rx_if u_if();

    uart_byte_rx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (u_if.master)
    );

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned exp_cyc[$];
    bit          exp_ok[$];
    logic [7:0]  exp_dat[$];
    logic [7:0]  model_data = 8'h00;
    logic [7:0]  got[$];
    int unsigned flag_cyc[$];
    int          err_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    always @(negedge sys_clk) begin
        logic exp_flag;
        logic exp_err;
        exp_flag = 1'b0;
        exp_err  = 1'b0;
        if (!sys_rst_n) begin
            model_data = 8'h00;
            exp_cyc.delete();
            exp_ok.delete();
            exp_dat.delete();
        end else if (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
            if (exp_cyc[0] == cyc) begin
                if (exp_ok[0]) begin
                    exp_flag   = 1'b1;
                    model_data = exp_dat[0];
                end else begin
                    exp_err = 1'b1;
                end
            end
            void'(exp_cyc.pop_front());
            void'(exp_ok.pop_front());
            void'(exp_dat.pop_front());
        end
        chk("po_flag", int'(u_if.po_flag), int'(exp_flag));
        chk("frame_err", int'(u_if.frame_err), int'(exp_err));
        chk("po_data", int'(u_if.po_data), int'(model_data));
        if (u_if.po_flag === 1'b1) begin
            got.push_back(u_if.po_data);
            flag_cyc.push_back(cyc);
        end
        if (u_if.frame_err === 1'b1) err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input bit expect_it,
                              input int idle_bits, output int unsigned t0);
        u_if.rx = 1'b0;
        t0 = cyc;
        if (expect_it) begin
            exp_cyc.push_back(cyc + LAT);
            exp_ok.push_back(stop);
            exp_dat.push_back(d);
        end
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            u_if.rx = d[i];
            tick(BAUD);
        end
        u_if.rx = stop;
        tick(BAUD);
        u_if.rx = 1'b1;
        tick(idle_bits * BAUD);
    endtask

    initial begin
        int unsigned t0;
        int          col_gold[4];
        int          col_sum;
        col_gold = '{45, 50, 55, 60};
        u_if.rx = 1'b1;
        tick(5);
        sys_rst_n = 1'b1;
        tick(5);

        // 1: single byte, latency pinned by hand.
        send_frame(8'h55, 1'b1, 1'b1, 2, t0);
        chk("t1_count", got.size(), 1);
        chk("t1_data", int'(got[0]), 'h55);
        chk("t1_latency", int'(flag_cyc[0] - t0), 99);
        chk("t1_no_err", err_cnt, 0);

        // 2: back-to-back frames.
        send_frame(8'hA3, 1'b1, 1'b1, 0, t0);
        send_frame(8'h0F, 1'b1, 1'b1, 2, t0);
        chk("t2_count", got.size(), 3);
        chk("t2_data0", int'(got[1]), 'hA3);
        chk("t2_data1", int'(got[2]), 'h0F);
        chk("t2_spacing", int'(flag_cyc[2] - flag_cyc[1]), 100);

        // 3: 3-clock glitch is rejected, following frame still lands.
        u_if.rx = 1'b0;
        tick(3);
        u_if.rx = 1'b1;
        tick(20);
        chk("t3_glitch_none", got.size(), 3);
        send_frame(8'h3C, 1'b1, 1'b1, 2, t0);
        chk("t3_count", got.size(), 4);
        chk("t3_data", int'(got[3]), 'h3C);

        // 4: stop bit low -> frame error, data holds.
        send_frame(8'h81, 1'b0, 1'b1, 2, t0);
        chk("t4_err_count", err_cnt, 1);
        chk("t4_no_flag", got.size(), 4);
        chk("t4_data_hold", int'(u_if.po_data), 'h3C);

        // 5: reset in the middle of bit 4 of 0xFF.
        u_if.rx = 1'b0;
        tick(BAUD);
        u_if.rx = 1'b1;
        tick(4 * BAUD + 5);
        sys_rst_n = 1'b0;
        tick(1);
        chk("t5_rst_data", int'(u_if.po_data), 0);
        tick(19);
        sys_rst_n = 1'b1;
        tick(30);
        chk("t5_no_strobe", got.size(), 4);
        send_frame(8'h12, 1'b1, 1'b1, 2, t0);
        chk("t5_count", got.size(), 5);
        chk("t5_data", int'(got[4]), 'h12);

        // 6: 20-byte stream, column sums of a 5-row x 4-column matrix.
        for (int b = 1; b <= 20; b++) begin
            send_frame(8'(b), 1'b1, 1'b1, 0, t0);
        end
        tick(3 * BAUD);
        chk("t6_count", got.size(), 25);
        for (int c = 0; c < 4; c++) begin
            col_sum = 0;
            for (int r = 0; r < 5; r++) col_sum += int'(got[5 + r * 4 + c]);
            chk($sformatf("t6_colsum%0d", c), col_sum, col_gold[c]);
        end

        tick(50);
        chk("pending_empty", exp_cyc.size(), 0);
        chk("final_err_count", err_cnt, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
